parity_frame_checker: RTL

- Receive end of the parity-protected serial nibble link.
- Deserialises a frame on a bit-strobe (clock enable): start bit, DATA_W data bits LSB first, parity bit, stop bit.
- Recomputes XOR parity over the data, flags parity and framing errors, presents the word with a one-cycle valid pulse, and keeps a saturating error count.
- Sits between the link pad synchroniser and the consumer logic.

---
 rtl/parity_link_pkg.sv | 22 ++
 rtl/parity_frame_checker_cnt.sv | 28 ++
 rtl/parity_frame_checker.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/parity_link_pkg.sv
// Shared definitions for the parity-protected serial nibble link.
// Used by both the receive checker and the transmit side.
package parity_link_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam logic LINE_IDLE = 1'b1;

    // Parity bit the sender should append; zero-extension keeps XOR intact.
    function automatic logic par_calc(
        input logic [31:0] data,
        input logic        odd
    );
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/parity_frame_checker_cnt.sv
// Saturating error counter for the link receiver.
// Clear has priority over increment.
module sat_err_counter #(
    parameter int CNT_W = 8
) (
    input  logic             Clk_CI,
    input  logic             Rst_RBI,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Count up to all-ones and stick there until cleared.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/parity_frame_checker.sv
// Receive end of the parity-protected serial nibble link.
// Define PFC_ERR_CNT_EN to build the saturating error counter.
module parity_frame_checker
    import parity_link_pkg::*;
#(
    parameter int DATA_W     = 4,
    parameter int ODD_PARITY = 0,
    parameter int CNT_W      = 8
) (
    input  logic              Clk_CI,
    input  logic              Rst_RBI,
    input  logic              Clk_En_SI,
    input  logic              SerIn_DI,
    input  logic              ErrClr_SI,
    output logic [DATA_W-1:0] Data_DO,
    output logic              Valid_SO,
    output logic              ParErr_SO,
    output logic              FrmErr_SO,
    output logic [CNT_W-1:0]  ErrCnt_DO
);

    localparam int BC_W = $clog2(DATA_W + 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_nxt;
    logic [BC_W-1:0]   r_bit_cnt;
    logic              r_par;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_par_err;
    logic              r_frm_err;
    logic              w_start;
    logic              w_shift;
    logic              w_par_en;
    logic              w_done;
    logic              w_last;
    logic              w_par_err;
    logic              w_err;

    assign w_last = (r_bit_cnt == BC_W'(DATA_W - 1));

    assign w_shift_nxt = (r_shift >> 1)
                       | (DATA_W'(SerIn_DI) << (DATA_W - 1));

    assign w_par_err = par_calc(32'(r_shift), ODD_PARITY != 0) != r_par;
    assign w_err     = w_par_err | ~SerIn_DI;

    // State register.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: only moves on strobe cycles.
    always_comb begin
        w_state_nxt = r_state;
        if (Clk_En_SI) begin
            unique case (r_state)
                IDLE:    if (SerIn_DI != LINE_IDLE) w_state_nxt = DATA;
                DATA:    if (w_last) w_state_nxt = PARITY;
                PARITY:  w_state_nxt = STOP;
                STOP:    w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Per-state datapath enables.
    always_comb begin
        w_start  = 1'b0;
        w_shift  = 1'b0;
        w_par_en = 1'b0;
        w_done   = 1'b0;
        if (Clk_En_SI) begin
            unique case (1'b1)
                (r_state == IDLE):   w_start  = (SerIn_DI != LINE_IDLE);
                (r_state == DATA):   w_shift  = 1'b1;
                (r_state == PARITY): w_par_en = 1'b1;
                (r_state == STOP):   w_done   = 1'b1;
                default: ;
            endcase
        end
    end

    // Deserialiser: first bit received lands in bit 0.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_par     <= 1'b0;
        end else begin
            if (w_start) begin
                r_bit_cnt <= '0;
            end
            if (w_shift) begin
                r_shift   <= w_shift_nxt;
                r_bit_cnt <= r_bit_cnt + BC_W'(1);
            end
            if (w_par_en) begin
                r_par <= SerIn_DI;
            end
        end
    end

    // Result registers; valid is a single-cycle pulse.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
        end else begin
            r_valid <= w_done;
            if (w_done) begin
                r_data    <= r_shift;
                r_par_err <= w_par_err;
                r_frm_err <= ~SerIn_DI;
            end
        end
    end

    assign Data_DO   = r_data;
    assign Valid_SO  = r_valid;
    assign ParErr_SO = r_par_err;
    assign FrmErr_SO = r_frm_err;

`ifdef PFC_ERR_CNT_EN
    sat_err_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .Clk_CI  (Clk_CI),
        .Rst_RBI (Rst_RBI),
        .i_inc   (w_done & w_err),
        .i_clr   (ErrClr_SI),
        .o_cnt   (ErrCnt_DO)
    );
`else
    logic w_unused;
    assign w_unused  = ErrClr_SI ^ w_err;
    assign ErrCnt_DO = '0;
`endif

endmodule
